// File: rtl/otp_pkg.sv
// ---------------------------------------------------------------------------
// otp_pkg
// Shared definitions for the OTP boot-time shadow loader:
//   - otp_state_e : loader FSM state encoding
//   - DEF_T_*     : default macro read-timing phase lengths (in clk cycles)
//   - CNT_W       : phase-timer width for the default timings
//   - max3()      : helper used to size the phase timer for any timing set
// ---------------------------------------------------------------------------
package otp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FINISH = 3'd5
  } otp_state_e;

  localparam int DEF_T_SETUP  = 2;
  localparam int DEF_T_STROBE = 4;
  localparam int DEF_T_HOLD   = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_W = $clog2(max3(DEF_T_SETUP, DEF_T_STROBE, DEF_T_HOLD) + 1);

endpackage

// File: rtl/otp_phase_timer.sv
// ---------------------------------------------------------------------------
// otp_phase_timer
// Loadable down-counter that times one FSM phase. Loading value N makes
// expired_o rise in the N-th cycle after the load edge, so a state that
// leaves on expired_o lasts exactly N cycles. The counter saturates at 0.
// Ports:
//   sys_clk     in  clock
//   rst         in  asynchronous active-high reset
//   load_i      in  load load_val_i on the next edge
//   load_val_i  in  phase length in cycles (>= 1)
//   expired_o   out current phase is in its last cycle
// ---------------------------------------------------------------------------
module otp_phase_timer
  import otp_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q <= WIDTH'(1));

endmodule

// File: rtl/otp_boot_loader.sv
// ---------------------------------------------------------------------------
// otp_boot_loader
// Boot-time OTP shadow loader. On i_start it reads NUM_BYTES consecutive OTP
// bytes through the macro read pins (csb/load/strobe), writes each byte to
// the register file over xbus, and checks that the last byte equals the XOR
// of all preceding bytes.
// Ports:
//   sys_clk, rst    clock, asynchronous active-high reset
//   i_start         start pulse, only honoured in IDLE
//   i_otp_q         OTP macro read data
//   o_otp_csb       macro chip select (active low)
//   o_otp_load      macro read-path enable
//   o_otp_strobe    macro read strobe
//   o_otp_pgenb     program enable bar, tied high (read only)
//   o_otp_vddqsw    program supply switch, tied low
//   o_otp_addr      OTP byte address
//   xbus_addr/din   register-file write address/data
//   xbus_wr         register-file write strobe, one cycle per byte
//   o_busy          load in progress (through FINISH)
//   o_done          one-cycle completion pulse
//   o_chk_err       sticky checksum mismatch, cleared on accepted start
// ---------------------------------------------------------------------------
module otp_boot_loader
  import otp_pkg::*;
#(
  parameter int                NUM_BYTES = 16,
  parameter int                ADDR_W    = 7,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                T_SETUP   = DEF_T_SETUP,
  parameter int                T_STROBE  = DEF_T_STROBE,
  parameter int                T_HOLD    = DEF_T_HOLD
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_otp_q,
  output logic              o_otp_csb,
  output logic              o_otp_load,
  output logic              o_otp_strobe,
  output logic              o_otp_pgenb,
  output logic              o_otp_vddqsw,
  output logic [ADDR_W-1:0] o_otp_addr,
  output logic [ADDR_W-1:0] xbus_addr,
  output logic [7:0]        xbus_din,
  output logic              xbus_wr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_chk_err
);

  localparam int                TIMER_W  = $clog2(max3(T_SETUP, T_STROBE, T_HOLD) + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

  otp_state_e state_q, state_d;

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        chk_q, chk_d;
  logic              csb_q, csb_d;
  logic              load_q, load_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] otp_addr_q, otp_addr_d;
  logic [ADDR_W-1:0] xbus_addr_q, xbus_addr_d;
  logic [7:0]        xbus_din_q, xbus_din_d;
  logic              xbus_wr_q, xbus_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              chk_err_q, chk_err_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_expired;

  otp_phase_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expired_o  (timer_expired)
  );

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_start)       state_d = ST_SETUP;
      ST_SETUP:  if (timer_expired) state_d = ST_STROBE;
      ST_STROBE: if (timer_expired) state_d = ST_HOLD;
      ST_HOLD:   if (timer_expired) state_d = ST_WRITE;
      ST_WRITE:  state_d = (idx_q == LAST_IDX) ? ST_FINISH : ST_SETUP;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-value logic. Everything is computed on the edge
  // that leaves a state, so every pin changes exactly at a phase boundary.
  always_comb begin
    idx_d       = idx_q;
    data_d      = data_q;
    chk_d       = chk_q;
    csb_d       = csb_q;
    load_d      = load_q;
    strobe_d    = strobe_q;
    otp_addr_d  = otp_addr_q;
    xbus_addr_d = xbus_addr_q;
    xbus_din_d  = xbus_din_q;
    xbus_wr_d   = xbus_wr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    chk_err_d   = chk_err_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          timer_load = 1'b1;
          timer_val  = TIMER_W'(T_SETUP);
          idx_d      = '0;
          chk_d      = '0;
          chk_err_d  = 1'b0;
          csb_d      = 1'b0;
          load_d     = 1'b1;
          otp_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_SETUP: begin
        if (timer_expired) begin
          strobe_d   = 1'b1;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(T_STROBE);
        end
      end
      ST_STROBE: begin
        // Data is sampled while strobe is still high, on the falling edge.
        if (timer_expired) begin
          data_d     = i_otp_q;
          strobe_d   = 1'b0;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(T_HOLD);
        end
      end
      ST_HOLD: begin
        if (timer_expired) begin
          xbus_wr_d   = 1'b1;
          xbus_addr_d = BASE_ADDR + idx_q;
          xbus_din_d  = data_q;
        end
      end
      ST_WRITE: begin
        xbus_wr_d = 1'b0;
        if (idx_q != LAST_IDX) begin
          // Payload byte: fold into the running checksum, move to the next.
          chk_d      = chk_q ^ data_q;
          idx_d      = idx_q + 1'b1;
          otp_addr_d = idx_q + 1'b1;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(T_SETUP);
        end else begin
          // Checksum byte: compare against the XOR of all payload bytes.
          chk_err_d = (chk_q != data_q);
          csb_d     = 1'b1;
          load_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      ST_FINISH: begin
        done_d = 1'b0;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      csb_q       <= 1'b1;
      load_q      <= 1'b0;
      strobe_q    <= 1'b0;
      otp_addr_q  <= '0;
      xbus_addr_q <= '0;
      xbus_din_q  <= '0;
      xbus_wr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      csb_q       <= csb_d;
      load_q      <= load_d;
      strobe_q    <= strobe_d;
      otp_addr_q  <= otp_addr_d;
      xbus_addr_q <= xbus_addr_d;
      xbus_din_q  <= xbus_din_d;
      xbus_wr_q   <= xbus_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign o_otp_csb    = csb_q;
  assign o_otp_load   = load_q;
  assign o_otp_strobe = strobe_q;
  assign o_otp_pgenb  = 1'b1;
  assign o_otp_vddqsw = 1'b0;
  assign o_otp_addr   = otp_addr_q;
  assign xbus_addr    = xbus_addr_q;
  assign xbus_din     = xbus_din_q;
  assign xbus_wr      = xbus_wr_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_chk_err    = chk_err_q;

endmodule
